// File: rtl/mm_skew_pkg.sv
// mm_skew_pkg: shared types and constants for the MXU skew staging buffer.
package mm_skew_pkg;

    // Default MXU edge and the widths derived from it
    localparam int DIM_DEF    = 16;
    localparam int LANE_W_DEF = (DIM_DEF > 1) ? $clog2(DIM_DEF) : 1;
    localparam int BEAT_W_DEF = LANE_W_DEF + 1;

    // Lane ordering modes
    localparam logic MODE_W = 1'b0;  // weight: lane i <- entry i
    localparam logic MODE_I = 1'b1;  // input: lane order reversed

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/mm_skew_lane_sel.sv
// mm_skew_lane_sel: picks one element out of a staged RAM word for one MXU lane.
// Indices past the end of the word read as zero; there is no fetch from the next word.
module mm_skew_lane_sel
    import mm_skew_pkg::*;
#(
    parameter int DIM    = DIM_DEF,
    parameter int ELEM_W = 8,
    parameter int IDX_W  = BEAT_W_DEF
) (
    input  logic [DIM*ELEM_W-1:0] word,
    input  logic [IDX_W-1:0]      idx,
    output logic [ELEM_W-1:0]     elem
);

    localparam int SEL_W = (DIM > 1) ? $clog2(DIM) : 1;

    logic [DIM-1:0][ELEM_W-1:0] elems;

    assign elems = word;

    // Element mux with zero fill past the word boundary
    always_comb begin
        elem = '0;
        if (idx < IDX_W'(DIM)) begin
            elem = elems[idx[SEL_W-1:0]];
        end
    end

endmodule

// File: rtl/mm_skew_buffer.sv
// mm_skew_buffer: fetches up to DIM rows from scratch RAM into local entries, then
// streams them to the MXU as a diagonally skewed wavefront with ready/valid stalls.
// Build option: MM_SKEW_ZERO_PAD_EN -- lanes with mxu_vld=0 drive zero data;
// without it invalid-lane data is don't-care.
module mm_skew_buffer
    import mm_skew_pkg::*;
#(
    parameter int DIM    = DIM_DEF,
    parameter int ELEM_W = 8,
    parameter int RAM_AW = 8,
    parameter int OFF_W  = LANE_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic [OFF_W-1:0]        cfg_row_len,
    input  logic [OFF_W-1:0]        cfg_col_len,
    input  logic [RAM_AW+OFF_W-1:0] cfg_start_addr,
    input  logic                    cfg_mode,
    output logic                    ram_rd_vld,
    output logic [RAM_AW-1:0]       ram_rd_addr,
    input  logic                    ram_rsp_vld,
    input  logic [DIM*ELEM_W-1:0]   ram_rsp_data,
    output logic [DIM-1:0]          mxu_vld,
    output logic [DIM*ELEM_W-1:0]   mxu_data,
    input  logic                    mxu_rdy,
    output logic                    mxu_end,
    output logic                    busy
);

    localparam int BEAT_W = OFF_W + 1;

    typedef struct packed {
        logic [OFF_W-1:0]  row_len;
        logic [OFF_W-1:0]  col_len;
        logic [RAM_AW-1:0] base;
        logic [OFF_W-1:0]  offset;
        logic              mode;
    } cfg_t;

    state_t                          state;
    cfg_t                            cfg_q;
    logic [BEAT_W-1:0]               req_cnt;
    logic [BEAT_W-1:0]               rsp_cnt;
    logic [BEAT_W-1:0]               t_cnt;
    logic [BEAT_W-1:0]               t_nxt;
    logic [BEAT_W-1:0]               n_words;
    logic [BEAT_W-1:0]               last_beat;
    logic                            rsp_take;
    logic [DIM-1:0][DIM*ELEM_W-1:0]  entry;
    logic [DIM-1:0]                  lane_vld;
    logic [DIM-1:0][ELEM_W-1:0]      lane_data;

    assign n_words   = {1'b0, cfg_q.col_len} + BEAT_W'(1);
    assign last_beat = {1'b0, cfg_q.row_len} + {1'b0, cfg_q.col_len};
    // Outputs are registered one beat ahead: LOAD prepares beat 0, STREAM prepares t+1
    assign t_nxt     = (state == STREAM) ? t_cnt + BEAT_W'(1) : '0;
    assign rsp_take  = (state == LOAD) && ram_rsp_vld && (rsp_cnt < n_words);

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        localparam logic [BEAT_W-1:0] LANE = BEAT_W'(i);

        logic [OFF_W-1:0]  ent_idx;
        logic [BEAT_W-1:0] el_idx;
        logic [ELEM_W-1:0] elem;

        assign ent_idx = (cfg_q.mode == MODE_I) ? cfg_q.col_len - OFF_W'(i) : OFF_W'(i);
        // Only meaningful when the lane is valid; garbage otherwise
        assign el_idx  = t_nxt - LANE + BEAT_W'(cfg_q.offset);
        assign lane_vld[i] = (LANE <= {1'b0, cfg_q.col_len}) &&
                             (t_nxt >= LANE) &&
                             (t_nxt <= LANE + {1'b0, cfg_q.row_len});

        mm_skew_lane_sel #(
            .DIM    (DIM),
            .ELEM_W (ELEM_W),
            .IDX_W  (BEAT_W)
        ) u_sel (
            .word (entry[ent_idx]),
            .idx  (el_idx),
            .elem (elem)
        );

`ifdef MM_SKEW_ZERO_PAD_EN
        assign lane_data[i] = lane_vld[i] ? elem : '0;
`else
        assign lane_data[i] = elem;
`endif
    end

    // Entry storage: capture RAM responses in order; deliberately not reset
    always_ff @(posedge clk) begin
        if (!rst && rsp_take) begin
            entry[rsp_cnt[OFF_W-1:0]] <= ram_rsp_data;
        end
    end

    // Control FSM: config latch, RAM request issue, beat sequencing, registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cfg_q.row_len <= '0;
            cfg_q.col_len <= '0;
            cfg_q.base    <= '0;
            cfg_q.offset  <= '0;
            cfg_q.mode    <= MODE_W;
            req_cnt       <= '0;
            rsp_cnt       <= '0;
            t_cnt         <= '0;
            ram_rd_vld    <= 1'b0;
            ram_rd_addr   <= '0;
            mxu_vld       <= '0;
            mxu_data      <= '0;
            mxu_end       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ram_rd_vld <= 1'b0;
                    if (cfg_start) begin
                        cfg_q.row_len <= cfg_row_len;
                        cfg_q.col_len <= cfg_col_len;
                        cfg_q.base    <= cfg_start_addr[RAM_AW+OFF_W-1:OFF_W];
                        cfg_q.offset  <= cfg_start_addr[OFF_W-1:0];
                        cfg_q.mode    <= cfg_mode;
                        req_cnt       <= '0;
                        rsp_cnt       <= '0;
                        t_cnt         <= '0;
                        busy          <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    if (req_cnt < n_words) begin
                        ram_rd_vld  <= 1'b1;
                        ram_rd_addr <= cfg_q.base + RAM_AW'(req_cnt);
                        req_cnt     <= req_cnt + BEAT_W'(1);
                    end else begin
                        ram_rd_vld  <= 1'b0;
                    end
                    if (rsp_take) begin
                        rsp_cnt <= rsp_cnt + BEAT_W'(1);
                    end
                    if (rsp_cnt == n_words) begin
                        t_cnt    <= '0;
                        mxu_vld  <= lane_vld;
                        mxu_data <= lane_data;
                        mxu_end  <= (t_nxt == last_beat);
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (mxu_rdy) begin
                        if (t_cnt == last_beat) begin
                            mxu_vld  <= '0;
                            mxu_data <= '0;
                            mxu_end  <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            t_cnt    <= t_nxt;
                            mxu_vld  <= lane_vld;
                            mxu_data <= lane_data;
                            mxu_end  <= (t_nxt == last_beat);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_skew_buffer.sv
// tb_mm_skew_buffer: directed tiles against a beat-list model of the skew wavefront,
// with an in-bench RAM of variable latency and optional random MXU backpressure.
`timescale 1ns/1ps
module tb_mm_skew_buffer;
    import mm_skew_pkg::*;

    localparam int DIM = 16, ELEM_W = 8, RAM_AW = 8, OFF_W = 4, DW = DIM * ELEM_W;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cfg_start = 1'b0;
    logic [OFF_W-1:0]        cfg_row_len = '0;
    logic [OFF_W-1:0]        cfg_col_len = '0;
    logic [RAM_AW+OFF_W-1:0] cfg_start_addr = '0;
    logic                    cfg_mode = 1'b0;
    logic                    ram_rd_vld;
    logic [RAM_AW-1:0]       ram_rd_addr;
    logic                    ram_rsp_vld = 1'b0;
    logic [DW-1:0]           ram_rsp_data = '0;
    logic [DIM-1:0]          mxu_vld;
    logic [DW-1:0]           mxu_data;
    logic                    mxu_rdy = 1'b1;
    logic                    mxu_end;
    logic                    busy;

    mm_skew_buffer #(.DIM(DIM), .ELEM_W(ELEM_W), .RAM_AW(RAM_AW), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_row_len(cfg_row_len),
        .cfg_col_len(cfg_col_len), .cfg_start_addr(cfg_start_addr), .cfg_mode(cfg_mode),
        .ram_rd_vld(ram_rd_vld), .ram_rd_addr(ram_rd_addr), .ram_rsp_vld(ram_rsp_vld),
        .ram_rsp_data(ram_rsp_data), .mxu_vld(mxu_vld), .mxu_data(mxu_data),
        .mxu_rdy(mxu_rdy), .mxu_end(mxu_end), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DIM-1:0] vld; logic [DW-1:0] data; logic last; } beat_s;
    typedef struct { logic [RAM_AW-1:0] addr; int due; } rd_s;

    beat_s exp_q[$];
    rd_s   rd_q[$];
    int checks = 0, errors = 0, cyc = 0, n_acc = 0, n_req = 0, lat_max = 1, last_due = 0;
    int cur_col = 0;
    bit rdy_rand = 1'b0, spur = 1'b0, chk_idle = 1'b0, hold_chk = 1'b0;
    logic [DIM-1:0]    got_vld [32];
    logic [DW-1:0]     got_data[32];
    logic              got_end [32];
    logic [RAM_AW-1:0] got_addr[32];
    logic [DIM-1:0]    prev_vld;
    logic [DW-1:0]     prev_data, msk;
    logic              prev_end;
    beat_s             cur_b;
    rd_s               rq;
    int                lat;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM contents: element j of word a = {a[3:0], j} ^ a[7:4]
    function automatic logic [DW-1:0] mem_word(logic [RAM_AW-1:0] a);
        logic [DW-1:0] w;
        for (int j = 0; j < DIM; j++) w[j*8 +: 8] = {a[3:0], 4'(j)} ^ {4'h0, a[7:4]};
        return w;
    endfunction

    // Expected beat t of a tile straight from the wavefront rules
    function automatic beat_s model_beat(int row, int col, int wa, int off, bit mode, int t);
        beat_s b;
        b.vld = '0; b.data = '0; b.last = (t == row + col);
        for (int i = 0; i < DIM; i++) begin
            if (i <= col && t >= i && t <= i + row) begin
                int e, k;
                logic [DW-1:0] w;
                e = mode ? col - i : i;
                k = t - i + off;
                b.vld[i] = 1'b1;
                w = mem_word(RAM_AW'(wa + e));
                if (k < DIM) b.data[i*8 +: 8] = w[k*8 +: 8];
            end
        end
        return b;
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RAM responder plus per-cycle output compare and ready generation
    initial forever begin
        @(negedge clk);
        if (ram_rd_vld === 1'b1) begin
            if (n_req < 32) got_addr[n_req] = ram_rd_addr;
            n_req++;
            lat = (lat_max > 1) ? int'($urandom_range(lat_max, 1)) : 1;
            rq.addr = ram_rd_addr;
            rq.due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = rq.due;
            rd_q.push_back(rq);
        end
        if (spur) begin
            ram_rsp_vld = 1'b1; ram_rsp_data = {4{32'hDEADBEEF}};
        end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            ram_rsp_vld = 1'b1; ram_rsp_data = mem_word(rd_q[0].addr);
            void'(rd_q.pop_front());
        end else begin
            ram_rsp_vld = 1'b0; ram_rsp_data = {4{$urandom}};
        end

        mxu_rdy = rdy_rand ? ($urandom_range(1, 0) == 1) : 1'b1;
        if (chk_idle) begin
            chk("idle_busy", busy, 0);
            chk("idle_vld", mxu_vld, 0);
            chk_idle = 1'b0;
        end
        if (hold_chk) begin
            chk("stall_vld", mxu_vld, prev_vld);
            chk("stall_data", mxu_data, prev_data);
            chk("stall_end", mxu_end, prev_end);
            hold_chk = 1'b0;
        end
        if (mxu_vld !== '0 && !rst) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL extra_beat: got vld %h expected no beat", mxu_vld);
            end else begin
                cur_b = exp_q[0];
`ifdef MM_SKEW_ZERO_PAD_EN
                msk = '1;
`else
                for (int i = 0; i < DIM; i++) msk[i*8 +: 8] = {8{cur_b.vld[i]}};
`endif
                chk("beat_vld", mxu_vld, cur_b.vld);
                chk("beat_data", mxu_data & msk, cur_b.data & msk);
                chk("beat_end", mxu_end, cur_b.last);
                if (mxu_rdy) begin
                    if (n_acc < 32) begin
                        got_vld[n_acc] = mxu_vld; got_data[n_acc] = mxu_data; got_end[n_acc] = mxu_end;
                    end
                    n_acc++;
                    void'(exp_q.pop_front());
                    if (cur_b.last) chk_idle = 1'b1;
                end else begin
                    hold_chk = 1'b1;
                    prev_vld = mxu_vld; prev_data = mxu_data; prev_end = mxu_end;
                end
            end
        end
    end

    task automatic start_tile(int row, int col, int wa, int off, bit mode);
        exp_q.delete();
        n_acc = 0; n_req = 0; cur_col = col;
        for (int t = 0; t <= row + col; t++) exp_q.push_back(model_beat(row, col, wa, off, mode, t));
        @(negedge clk);
        cfg_row_len = OFF_W'(row); cfg_col_len = OFF_W'(col);
        cfg_start_addr = {RAM_AW'(wa), OFF_W'(off)}; cfg_mode = mode; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_row_len = 4'($urandom); cfg_col_len = 4'($urandom);
        cfg_start_addr = 12'($urandom); cfg_mode = 1'($urandom);
        chk("busy_rise", busy, 1);
    endtask

    task automatic wait_done(string name, int nbeats);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 4000) begin
            checks++; errors++;
            $display("FAIL %s_timeout: %0d beats left, expected 0", name, exp_q.size());
        end
        @(negedge clk);
        chk({name, "_beats"}, n_acc, nbeats);
        chk({name, "_reqs"}, n_req, cur_col + 1);
    endtask

    task automatic wait_acc(int n);
        int k;
        k = 0;
        while (n_acc < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) begin
            checks++; errors++;
            $display("FAIL wait_acc: got %0d beats expected %0d", n_acc, n);
        end
    endtask

    initial begin
        beat_s pb;
        repeat (3) @(negedge clk);
        chk("rst_rd_vld", ram_rd_vld, 0);
        chk("rst_mxu_vld", mxu_vld, 0);
        chk("rst_mxu_end", mxu_end, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", mxu_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Responses while idle must not be taken
        spur = 1'b1;
        repeat (2) @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("spur_busy", busy, 0);

        // 3x3 weight tile at word 0x10
        start_tile(2, 2, 'h10, 0, MODE_W);
        wait_done("t1", 5);
        chk("t1_addr0", got_addr[0], 8'h10);
        chk("t1_addr2", got_addr[2], 8'h12);
        chk("t1_vld0", got_vld[0], 16'h0001);
        chk("t1_vld1", got_vld[1], 16'h0003);
        chk("t1_vld2", got_vld[2], 16'h0007);
        chk("t1_vld3", got_vld[3], 16'h0006);
        chk("t1_vld4", got_vld[4], 16'h0004);
        chk("t1_end3", got_end[3], 0);
        chk("t1_end4", got_end[4], 1);
        chk("t1_b2_l0", got_data[2][7:0], 8'h03);
        chk("t1_b2_l1", got_data[2][15:8], 8'h10);
        chk("t1_b2_l2", got_data[2][23:16], 8'h21);

        // Same tile, input mode
        start_tile(2, 2, 'h10, 0, MODE_I);
        wait_done("t2", 5);
        chk("t2_b0_l0", got_data[0][7:0], 8'h21);
        chk("t2_b2_l0", got_data[2][7:0], 8'h23);
        chk("t2_b2_l2", got_data[2][23:16], 8'h01);

        // Offset 3 with full row length: tail elements fall off the word
        start_tile(15, 2, 'h20, 3, MODE_W);
        wait_done("t3", 18);
        pb = model_beat(15, 2, 'h20, 3, 1'b0, 13);
        chk("pin_pad_model", pb.data[7:0], 8'h00);
        chk("t3_b12_l0", got_data[12][7:0], 8'h0D);
        chk("t3_b13_l0", got_data[13][7:0], 8'h00);
        chk("t3_vld13", got_vld[13], 16'h0007);
        chk("t3_vld17", got_vld[17], 16'h0004);

        // Random backpressure and RAM latency, address wrap
        rdy_rand = 1'b1; lat_max = 4;
        start_tile(4, 6, 'hFE, 1, MODE_I);
        wait_done("t4a", 11);
        chk("t4a_wrap", got_addr[2], 8'h00);
        start_tile(6, 3, 'h7C, 5, MODE_W);
        wait_done("t4b", 10);
        rdy_rand = 1'b0; lat_max = 1;

        // cfg_start mid-stream ignored, then reset mid-tile
        start_tile(3, 3, 'h40, 0, MODE_W);
        wait_acc(1);
        cfg_row_len = '0; cfg_col_len = '0; cfg_start_addr = 12'h555; cfg_mode = 1'b1; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_acc(2);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rd_vld", ram_rd_vld, 0);
        chk("abort_vld", mxu_vld, 0);
        chk("abort_end", mxu_end, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", mxu_data, 0);
        exp_q.delete(); rd_q.delete(); last_due = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_tile(1, 2, 'h50, 2, MODE_I);
        wait_done("t5", 4);

        // Full 16x16 tiles under backpressure
        rdy_rand = 1'b1; lat_max = 3;
        start_tile(15, 15, 'h80, 0, MODE_W);
        wait_done("full_w", 31);
        start_tile(15, 15, 'hC8, 2, MODE_I);
        wait_done("full_i", 31);
        rdy_rand = 1'b0; lat_max = 1;

        // Length 0/0
        start_tile(0, 0, 'h33, 7, MODE_I);
        wait_done("t0", 1);
        chk("t0_vld", got_vld[0], 16'h0001);
        chk("t0_end", got_end[0], 1);
        chk("t0_data", got_data[0][7:0], 8'h34);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
